regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/wb_pkg.sv | 15 +
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   XLEN           : data path width
//   REG_IDX_W      : register index width
//   wb_arb_state_t : arbiter FSM states
package wb_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic {
    LSU_PRIO  = 1'b0,
    ALU_FORCE = 1'b1
  } wb_arb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter in front of a single register-file write port.
// The LSU normally has priority. After STARVE_LIMIT consecutive cycles in which
// the ALU was waiting and lost, the ALU is guaranteed the next grant.
//
// Ports
//   clk                      : clock, rising edge
//   reset                    : asynchronous reset, active low
//   alu_valid/rd_idx/rd_data : ALU writeback request (held until alu_ready)
//   alu_ready                : ALU request accepted this cycle
//   lsu_valid/rd_idx/rd_data : LSU writeback request (held until lsu_ready)
//   lsu_ready                : LSU request accepted this cycle
//   wb_we/rd_idx/rd_data     : registered register-file write, one cycle after the transfer
//   alu_starved              : high while the ALU is being forced through
//
// State      | meaning
// -----------+---------------------------------------------------------
// LSU_PRIO   | normal operation, LSU wins when both request
// ALU_FORCE  | ALU lost STARVE_LIMIT cycles in a row, ALU wins next
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd_idx,
  input  logic [XLEN-1:0]      alu_rd_data,
  output logic                 alu_ready,
  input  logic                 lsu_valid,
  input  logic [REG_IDX_W-1:0] lsu_rd_idx,
  input  logic [XLEN-1:0]      lsu_rd_data,
  output logic                 lsu_ready,
  output logic                 wb_we,
  output logic [REG_IDX_W-1:0] wb_rd_idx,
  output logic [XLEN-1:0]      wb_rd_data,
  output logic                 alu_starved
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  wb_arb_state_t   state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic             alu_xfer, lsu_xfer;

  // Grant. Reset is low-active; gating on it keeps both readys low while
  // reset is held, independent of the register contents.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (reset) begin
      if (state == LSU_PRIO) begin
        if (lsu_valid)      lsu_ready = 1'b1;
        else if (alu_valid) alu_ready = 1'b1;
      end else begin
        if (alu_valid)      alu_ready = 1'b1;
        else if (lsu_valid) lsu_ready = 1'b1;
      end
    end
  end

  assign alu_xfer    = alu_valid & alu_ready;
  assign lsu_xfer    = lsu_valid & lsu_ready;
  assign alu_starved = (state == ALU_FORCE);

  // Next state and starvation count. The count only tracks an unbroken run
  // of ALU losses; any idle ALU cycle or ALU win restarts it.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    state_nxt      = state;
    if (!alu_valid || alu_ready)  starve_cnt_nxt = '0;
    else if (starve_cnt != LIMIT_C) starve_cnt_nxt = starve_cnt + CNT_W'(1);
    unique case (state)
      LSU_PRIO:  if (starve_cnt_nxt == LIMIT_C)  state_nxt = ALU_FORCE;
      ALU_FORCE: if (!alu_valid || alu_ready)    state_nxt = LSU_PRIO;
      default:                                   state_nxt = LSU_PRIO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LSU_PRIO;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Registered write stage. Writes to x0 are accepted upstream but never
  // raise the enable; index/data hold between transfers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_we      <= 1'b0;
      wb_rd_idx  <= '0;
      wb_rd_data <= '0;
    end else if (alu_xfer) begin
      wb_we      <= (alu_rd_idx != '0);
      wb_rd_idx  <= alu_rd_idx;
      wb_rd_data <= alu_rd_data;
    end else if (lsu_xfer) begin
      wb_we      <= (lsu_rd_idx != '0);
      wb_rd_idx  <= lsu_rd_idx;
      wb_rd_data <= lsu_rd_data;
    end else begin
      wb_we      <= 1'b0;
    end
  end

endmodule
